// File: rtl/mem_port_arbiter.sv
// Arbitrates one main-memory port between the I-cache and D-cache refill/write-back paths.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; the default build uses fixed D-over-I priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic              d_mem_ready,
  output logic [DATA_W-1:0] cache_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        arb_owner
);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D, TURN} state_t;

  state_t state, state_nxt;
  logic   req_i, req_d;
  logic   prefer_d;

  assign req_i       = i_mem_read;
  assign req_d       = d_mem_read | d_mem_write;
  assign cache_rdata = mem_rdata;

`ifdef ARB_ROUND_ROBIN_EN
  // Last-owner pointer: 1 = D completed the most recent grant.
  logic last_d;

  always_ff @(posedge clk) begin
    if (!proc_reset_n)    last_d <= 1'b0;
    else if (i_mem_ready) last_d <= 1'b0;
    else if (d_mem_ready) last_d <= 1'b1;
  end

  assign prefer_d = ~last_d;
`else
  assign prefer_d = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!proc_reset_n) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    arb_owner   = 2'b00;
    case (state)
      // Memory outputs stay quiet here so a cache's first-cycle address-0 request never leaks.
      IDLE: begin
        if (req_d && (prefer_d || !req_i)) state_nxt = OWN_D;
        else if (req_i)                    state_nxt = OWN_I;
      end
      OWN_I: begin
        arb_owner = 2'b01;
        if (!req_i) begin
          state_nxt = IDLE;
        end else begin
          mem_read = 1'b1;
          mem_addr = i_mem_addr;
          if (mem_ready) begin
            i_mem_ready = 1'b1;
            state_nxt   = TURN;
          end
        end
      end
      OWN_D: begin
        arb_owner = 2'b10;
        if (!req_d) begin
          state_nxt = IDLE;
        end else begin
          mem_read  = d_mem_read;
          mem_write = d_mem_write;
          mem_addr  = d_mem_addr;
          mem_wdata = d_mem_wdata;
          if (mem_ready) begin
            d_mem_ready = 1'b1;
            state_nxt   = TURN;
          end
        end
      end
      // Dead cycle lets the finishing cache leave its buffer state before re-arbitration.
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter; each vector covers one clock cycle.
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset_n;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_addr;
  logic          i_mem_ready;
  logic          d_mem_read, d_mem_write;
  logic [AW-1:0] d_mem_addr;
  logic [DW-1:0] d_mem_wdata;
  logic          d_mem_ready;
  logic [DW-1:0] cache_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [1:0]    arb_owner;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_ready(d_mem_ready), .cache_rdata(cache_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .arb_owner(arb_owner)
  );

  typedef struct {
    string         name;
    logic          rst_n, ir;
    logic [AW-1:0] ia;
    logic          dr, dw;
    logic [AW-1:0] da;
    logic [DW-1:0] wd;
    logic          rdy;
    logic          emr, emw;
    logic [AW-1:0] ema;
    logic [DW-1:0] emwd;
    logic          eir, edr;
    logic [1:0]    eown;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  bit   d_wins[3];

  localparam logic [DW-1:0] BEEF = 128'hDEAD_BEEF;
  localparam logic [DW-1:0] WD5  = 128'h1234;

  task automatic add(input string name, input logic rst_n, input logic ir, input logic [AW-1:0] ia,
                     input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] wd,
                     input logic rdy, input logic emr, input logic emw, input logic [AW-1:0] ema,
                     input logic [DW-1:0] emwd, input logic eir, input logic edr, input logic [1:0] eown);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
    v.wd = wd; v.rdy = rdy; v.emr = emr; v.emw = emw; v.ema = ema; v.emwd = emwd;
    v.eir = eir; v.edr = edr; v.eown = eown;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    i_mem_read = 0; i_mem_addr = '0; d_mem_read = 0; d_mem_write = 0;
    d_mem_addr = '0; d_mem_wdata = '0; mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic check(input string name, input logic [299:0] got, input logic [299:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    int n;
    logic [DW-1:0] rd;
`ifdef ARB_ROUND_ROBIN_EN
    d_wins[0] = 1; d_wins[1] = 0; d_wins[2] = 1;
`else
    d_wins[0] = 1; d_wins[1] = 1; d_wins[2] = 1;
`endif
    //   name           rst ir ia          dr dw da          wd    rdy| mr mw ma          mwd   ir dr own
    add("reset_state",   0, 1, 28'h123,    1, 0, 28'h0,      '0,   0,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    add("t1_idle",       1, 1, 28'h123,    0, 0, 28'h0,      '0,   0,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    add("t1_own",        1, 1, 28'h123,    0, 0, 28'h0,      '0,   0,   1, 0, 28'h123,    '0,   0, 0, 2'b01);
    add("t1_ready",      1, 1, 28'h123,    0, 0, 28'h0,      '0,   1,   1, 0, 28'h123,    '0,   1, 0, 2'b01);
    add("t1_turn",       1, 0, 28'h0,      0, 0, 28'h0,      '0,   1,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    add("t1_idle_rdy",   1, 0, 28'h0,      0, 0, 28'h0,      '0,   1,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    add("t2_idle",       1, 0, 28'h0,      0, 1, 28'hAB,     BEEF, 0,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    add("t2_own",        1, 0, 28'h0,      0, 1, 28'hAB,     BEEF, 0,   0, 1, 28'hAB,     BEEF, 0, 0, 2'b10);
    add("t2_own_ireq",   1, 1, 28'h555,    0, 1, 28'hAB,     BEEF, 0,   0, 1, 28'hAB,     BEEF, 0, 0, 2'b10);
    add("t2_dready",     1, 1, 28'h555,    0, 1, 28'hAB,     BEEF, 1,   0, 1, 28'hAB,     BEEF, 0, 1, 2'b10);
    add("t2_turn",       1, 1, 28'h555,    0, 0, 28'h0,      '0,   0,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    add("t2_idle",       1, 1, 28'h555,    0, 0, 28'h0,      '0,   0,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    add("t2_grant_i",    1, 1, 28'h555,    0, 0, 28'h0,      '0,   0,   1, 0, 28'h555,    '0,   0, 0, 2'b01);
    add("t2_iready",     1, 1, 28'h555,    0, 0, 28'h0,      '0,   1,   1, 0, 28'h555,    '0,   1, 0, 2'b01);
    add("t2_turn2",      1, 0, 28'h0,      0, 0, 28'h0,      '0,   0,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    add("t4_addr0",      1, 0, 28'h0,      1, 0, 28'h0,      '0,   0,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    add("t4_addr",       1, 0, 28'h0,      1, 0, 28'hF00,    '0,   0,   1, 0, 28'hF00,    '0,   0, 0, 2'b10);
    add("t4_ready",      1, 0, 28'h0,      1, 0, 28'hF00,    '0,   1,   1, 0, 28'hF00,    '0,   0, 1, 2'b10);
    add("t4_turn",       1, 0, 28'h0,      0, 0, 28'h0,      '0,   0,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    add("t5_idle",       1, 0, 28'h0,      0, 1, 28'h77,     WD5,  0,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    add("t5_own",        1, 0, 28'h0,      0, 1, 28'h77,     WD5,  0,   0, 1, 28'h77,     WD5,  0, 0, 2'b10);
    add("t5_rst",        0, 0, 28'h0,      0, 1, 28'h77,     WD5,  0,   0, 1, 28'h77,     WD5,  0, 0, 2'b10);
    add("t5_after_rst",  1, 0, 28'h0,      0, 0, 28'h0,      '0,   1,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    add("t6_idle",       1, 1, 28'h321,    0, 0, 28'h0,      '0,   0,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    add("t6_own",        1, 1, 28'h321,    1, 0, 28'h9AB,    '0,   0,   1, 0, 28'h321,    '0,   0, 0, 2'b01);
    add("t6_abort",      1, 0, 28'h321,    1, 0, 28'h9AB,    '0,   0,   0, 0, 28'h0,      '0,   0, 0, 2'b01);
    add("t6_idle",       1, 0, 28'h0,      1, 0, 28'h9AB,    '0,   0,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    add("t6_grant_d",    1, 0, 28'h0,      1, 0, 28'h9AB,    '0,   0,   1, 0, 28'h9AB,    '0,   0, 0, 2'b10);
    add("t6_ready",      1, 0, 28'h0,      1, 0, 28'h9AB,    '0,   1,   1, 0, 28'h9AB,    '0,   0, 1, 2'b10);
    add("t6_turn",       1, 0, 28'h0,      0, 0, 28'h0,      '0,   0,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    add("t3_reset",      0, 0, 28'h0,      0, 0, 28'h0,      '0,   0,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    for (int r = 0; r < 3; r++) begin
      add("t3_idle",     1, 1, 28'h111,    1, 0, 28'h222,    '0,   0,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
      if (d_wins[r]) begin
        add("t3_own_d",  1, 1, 28'h111,    1, 0, 28'h222,    '0,   0,   1, 0, 28'h222,    '0,   0, 0, 2'b10);
        add("t3_rdy_d",  1, 1, 28'h111,    1, 0, 28'h222,    '0,   1,   1, 0, 28'h222,    '0,   0, 1, 2'b10);
      end else begin
        add("t3_own_i",  1, 1, 28'h111,    1, 0, 28'h222,    '0,   0,   1, 0, 28'h111,    '0,   0, 0, 2'b01);
        add("t3_rdy_i",  1, 1, 28'h111,    1, 0, 28'h222,    '0,   1,   1, 0, 28'h111,    '0,   1, 0, 2'b01);
      end
      add("t3_turn",     1, 0, 28'h0,      0, 0, 28'h0,      '0,   0,   0, 0, 28'h0,      '0,   0, 0, 2'b00);
    end

    // Unchecked reset cycle to bring the DUT out of its power-up state.
    drive_idle();
    proc_reset_n = 0;
    @(posedge clk); #1;

    for (int k = 0; k < vecs.size(); k++) begin
      proc_reset_n = vecs[k].rst_n;
      i_mem_read   = vecs[k].ir;  i_mem_addr  = vecs[k].ia;
      d_mem_read   = vecs[k].dr;  d_mem_write = vecs[k].dw;
      d_mem_addr   = vecs[k].da;  d_mem_wdata = vecs[k].wd;
      mem_ready    = vecs[k].rdy;
      rd           = {4{32'hC0DE_0000 | 32'(k)}};
      mem_rdata    = rd;
      @(negedge clk);
      check(vecs[k].name,
            {mem_read, mem_write, mem_addr, mem_wdata, i_mem_ready, d_mem_ready, arb_owner, cache_rdata},
            {vecs[k].emr, vecs[k].emw, vecs[k].ema, vecs[k].emwd, vecs[k].eir, vecs[k].edr, vecs[k].eown, rd});
      @(posedge clk); #1;
    end

    // Hand-written: grant latency after reset with a bounded wait on arb_owner.
    drive_idle();
    proc_reset_n = 0;
    @(posedge clk); #1;
    proc_reset_n = 1;
    i_mem_read = 1; i_mem_addr = 28'hABC;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (arb_owner == 2'b01) break;
      @(posedge clk); #1;
      n++;
    end
    check("hs_grant_latency", 300'(n), 300'(1));
    check("hs_grant_addr", 300'({mem_read, mem_addr}), 300'({1'b1, 28'hABC}));
    @(posedge clk); #1;
    mem_ready = 1;
    @(negedge clk);
    check("hs_iready", 300'({i_mem_ready, d_mem_ready}), 300'(2'b10));
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("hs_turn_owner", 300'({arb_owner, mem_read}), 300'(3'b000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
